pc_ctrl_unit: RTL and testbench
===============================

Name: pc_ctrl_unit

Overview:
Parametrised program-counter controller for the IF stage. It holds the fetch PC and selects the next PC from sequential increment, ID-stage jump or EX-stage branch redirect. Redirects that arrive while the PC is frozen by stall or halt are buffered, not lost. It adds debug run/halt/single-step control, a saturating fetch counter and sticky misalignment detection for the debug unit.

Parameters:
DATA_W, 32, PC and target width
RESET_VEC, 0, PC value loaded on reset
PC_INC, 4, sequential increment
ALIGN_BITS, 2, low target bits that must be zero
CNT_W, 32, fetch counter width
START_HALTED, 0, 1 = leave reset in HALT state

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_stall  in  1  hazard stall; freezes PC
i_branch_taken  in  1  EX branch redirect request
i_branch_target  in  DATA_W  branch target
i_jump  in  1  ID jump redirect request
i_jump_target  in  DATA_W  jump target
i_dbg_run  in  1  debug: enter RUN
i_dbg_halt  in  1  debug: enter HALT
i_dbg_step  in  1  debug: single-step pulse
o_pc  out  DATA_W  current fetch PC
o_pc_plus  out  DATA_W  o_pc + PC_INC (combinational)
o_fetch_en  out  1  PC advances at next edge (combinational)
o_state  out  2  00 RUN, 01 HALT, 10 STEP
o_pending  out  1  buffered redirect waiting
o_misaligned  out  1  sticky misaligned-target flag
o_fetch_count  out  CNT_W  number of PC advances

Behaviour:
- Reset is asynchronous, active-high, on i_clk domain. On reset: o_pc=RESET_VEC; o_state=HALT if START_HALTED else RUN; pending=0; o_misaligned=0; o_fetch_count=0.
- adv = (state==RUN or state==STEP) and !i_stall. o_fetch_en = adv.
- Same-cycle redirect selection: branch over jump, because EX is older than ID. Call the winner req/tgt.
- Next-PC rules:
  - adv and req: o_pc <= tgt; pending cleared.
  - adv and !req and pending: o_pc <= pending target; pending cleared.
  - adv, no req, no pending: o_pc <= o_pc + PC_INC, modulo 2^DATA_W. Example: 0xFFFFFFFC -> 0x00000000.
  - !adv and req: tgt stored in pending register, pending=1. A later request overwrites an earlier pending one. o_pc holds.
  - !adv, no req: everything holds.
- Alignment: a target with any of its low ALIGN_BITS bits non-zero sets o_misaligned at the capture edge. The flag stays set until reset. Captured/loaded targets have those low bits forced to 0.
- o_fetch_count increments on every adv edge and saturates at all-ones.
- Debug FSM, command priority halt > step > run. Commands are sampled every cycle.
  - RUN: i_dbg_halt -> HALT.
  - HALT: i_dbg_step -> STEP; i_dbg_run -> RUN.
  - STEP: the first edge with adv -> HALT. That edge performs exactly one advance. If stalled, remain in STEP. i_dbg_halt in STEP -> HALT with no advance.
  - In RUN with i_dbg_halt: the halt wins that cycle, so adv is computed from the current state (RUN) and the PC still advances on that edge.
- Reset mid-step or with pending: all state returns to reset values immediately; the pending redirect is discarded.

Decomposition:
- Shared package pc_pkg holds the state encoding constants (ST_RUN=2'b00, ST_HALT=2'b01, ST_STEP=2'b10) and default RESET_VEC / PC_INC, for use by the debug unit.
- One sub-module: pc_redirect_buf. It contains the pending register, valid bit and alignment masking.
- FSM and counter remain in pc_ctrl_unit.

Test Plan:
- Reset then 3 cycles RUN, no stall -> o_pc 0x0,0x4,0x8,0xC; o_fetch_count=3.
- i_branch_taken=1 tgt 0x100 and i_jump=1 tgt 0x200 in the same cycle -> o_pc=0x100 next cycle.
- i_stall=1 for 2 cycles, jump tgt 0x40 in the first stalled cycle -> o_pending=1 and o_pc frozen; first unstalled edge -> o_pc=0x40, o_pending=0.
- HALT, i_dbg_step pulse with o_pc=0x20 -> o_state=STEP, then o_pc=0x24 and o_state=HALT; count +1 only.
- Branch tgt 0x102 -> o_pc=0x100, o_misaligned=1; flag stays 1 after subsequent aligned branches until i_reset.
- o_pc=0xFFFFFFFC, RUN -> wraps to 0x0. Assert i_reset asynchronously mid-cycle with pending=1 -> o_pc=RESET_VEC immediately, pending=0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg
// Shared definitions for the program-counter controller and the debug unit
// that observes it: debug-state encoding and default reset vector / increment.
package pc_pkg;

   // Debug run-control state, as presented on o_state.
   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_HALT = 2'b01,
      ST_STEP = 2'b10
   } pc_state_e;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam int          DEF_PC_INC    = 4;

endpackage : pc_pkg

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf
// Holds one redirect target that arrived while the PC could not advance, and
// applies alignment masking / sticky misalignment detection to targets.
// Ports:
//   i_clk, i_reset     clock, asynchronous active-high reset
//   i_req, i_tgt       winning redirect request and its raw target
//   i_adv              PC advances at this edge
//   o_tgt_aligned      i_tgt with the low ALIGN_BITS forced to zero
//   o_pending          a buffered redirect is waiting
//   o_pending_tgt      buffered (already aligned) target
//   o_misaligned       sticky: some captured target had low bits set
module pc_redirect_buf #(
   parameter int DATA_W     = 32,
   parameter int ALIGN_BITS = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req,
   input  logic [DATA_W-1:0] i_tgt,
   input  logic              i_adv,
   output logic [DATA_W-1:0] o_tgt_aligned,
   output logic              o_pending,
   output logic [DATA_W-1:0] o_pending_tgt,
   output logic              o_misaligned
);

   // Ones in the bits that must be zero for a legal target.
   localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'((64'd1 << ALIGN_BITS) - 64'd1);

   logic              valid_reg;
   logic [DATA_W-1:0] tgt_reg;
   logic              mis_reg;
   logic              tgt_bad;

   assign o_tgt_aligned = i_tgt & ~LOW_MASK;
   assign tgt_bad       = |(i_tgt & LOW_MASK);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_reg <= 1'b0;
         tgt_reg   <= '0;
         mis_reg   <= 1'b0;
      end else begin
         // An advancing edge always consumes the buffer: either the new
         // request or the buffered target is loaded into the PC.
         if (i_adv) begin
            valid_reg <= 1'b0;
         end else if (i_req) begin
            valid_reg <= 1'b1;
            tgt_reg   <= o_tgt_aligned;   // newest request wins
         end
         if (i_req && tgt_bad) begin
            mis_reg <= 1'b1;
         end
      end
   end

   assign o_pending     = valid_reg;
   assign o_pending_tgt = tgt_reg;
   assign o_misaligned  = mis_reg;

endmodule : pc_redirect_buf

// File: rtl/pc_ctrl_unit.sv
// pc_ctrl_unit
// IF-stage program-counter controller: sequential increment, ID jump and EX
// branch redirect (branch wins), buffered redirects across stall/halt, debug
// run/halt/single-step FSM and a saturating fetch counter.
// Ports:
//   i_clk, i_reset                      clock, asynchronous active-high reset
//   i_stall                             freezes the PC
//   i_branch_taken / i_branch_target    EX redirect
//   i_jump / i_jump_target              ID redirect
//   i_dbg_run / i_dbg_halt / i_dbg_step debug commands (halt > step > run)
//   o_pc, o_pc_plus                     fetch PC and PC + PC_INC
//   o_fetch_en                          PC advances at next edge
//   o_state                             00 RUN, 01 HALT, 10 STEP
//   o_pending, o_misaligned             buffered redirect, sticky alignment flag
//   o_fetch_count                       saturating count of PC advances
module pc_ctrl_unit
   import pc_pkg::*;
#(
   parameter int                DATA_W       = 32,
   parameter logic [DATA_W-1:0] RESET_VEC    = DATA_W'(DEF_RESET_VEC),
   parameter int                PC_INC       = DEF_PC_INC,
   parameter int                ALIGN_BITS   = 2,
   parameter int                CNT_W        = 32,
   parameter bit                START_HALTED = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_stall,
   input  logic              i_branch_taken,
   input  logic [DATA_W-1:0] i_branch_target,
   input  logic              i_jump,
   input  logic [DATA_W-1:0] i_jump_target,
   input  logic              i_dbg_run,
   input  logic              i_dbg_halt,
   input  logic              i_dbg_step,
   output logic [DATA_W-1:0] o_pc,
   output logic [DATA_W-1:0] o_pc_plus,
   output logic              o_fetch_en,
   output logic [1:0]        o_state,
   output logic              o_pending,
   output logic              o_misaligned,
   output logic [CNT_W-1:0]  o_fetch_count
);

   localparam pc_state_e RESET_STATE = START_HALTED ? ST_HALT : ST_RUN;

   pc_state_e         state_reg, state_next;
   logic [DATA_W-1:0] pc_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              adv;
   logic              req;
   logic [DATA_W-1:0] tgt;
   logic [DATA_W-1:0] tgt_aligned;
   logic [DATA_W-1:0] pend_tgt;
   logic              pend_valid;

   // EX is older than ID, so its redirect takes precedence.
   assign req = i_branch_taken | i_jump;
   assign tgt = i_branch_taken ? i_branch_target : i_jump_target;

   pc_redirect_buf #(
      .DATA_W     (DATA_W),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_redirect_buf (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_req         (req),
      .i_tgt         (tgt),
      .i_adv         (adv),
      .o_tgt_aligned (tgt_aligned),
      .o_pending     (pend_valid),
      .o_pending_tgt (pend_tgt),
      .o_misaligned  (o_misaligned)
   );

   // Debug FSM and advance enable. A halt in RUN still lets this edge
   // advance; a halt in STEP cancels the step's advance.
   always_comb begin
      state_next = state_reg;
      adv        = 1'b0;
      case (state_reg)
         ST_RUN: begin
            adv = !i_stall;
            if (i_dbg_halt) state_next = ST_HALT;
         end
         ST_HALT: begin
            if (i_dbg_halt)      state_next = ST_HALT;
            else if (i_dbg_step) state_next = ST_STEP;
            else if (i_dbg_run)  state_next = ST_RUN;
         end
         ST_STEP: begin
            adv = !i_stall && !i_dbg_halt;
            if (i_dbg_halt || !i_stall) state_next = ST_HALT;
         end
         default: state_next = ST_HALT;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg <= RESET_STATE;
         pc_reg    <= RESET_VEC;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (adv) begin
            if (req)             pc_reg <= tgt_aligned;
            else if (pend_valid) pc_reg <= pend_tgt;
            else                 pc_reg <= o_pc_plus;
            if (cnt_reg != '1)   cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign o_pc          = pc_reg;
   assign o_pc_plus     = pc_reg + DATA_W'(PC_INC);
   assign o_fetch_en    = adv;
   assign o_state       = state_reg;
   assign o_pending     = pend_valid;
   assign o_fetch_count = cnt_reg;

endmodule : pc_ctrl_unit

// File: tb/tb_pc_ctrl_unit.sv
// tb_pc_ctrl_unit
// Directed, table-driven bench for pc_ctrl_unit (default parameters) plus a
// hand-written asynchronous-reset sequence.
module tb_pc_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, br, jmp, run, halt, step;
   logic [31:0] bt, jt;
   logic [31:0] pc, pc_plus, cnt;
   logic        fetch_en, pending, misaligned;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_ctrl_unit dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_stall         (stall),
      .i_branch_taken  (br),
      .i_branch_target (bt),
      .i_jump          (jmp),
      .i_jump_target   (jt),
      .i_dbg_run       (run),
      .i_dbg_halt      (halt),
      .i_dbg_step      (step),
      .o_pc            (pc),
      .o_pc_plus       (pc_plus),
      .o_fetch_en      (fetch_en),
      .o_state         (state),
      .o_pending       (pending),
      .o_misaligned    (misaligned),
      .o_fetch_count   (cnt)
   );

   localparam logic [1:0] RUN = 2'b00, HLT = 2'b01, STP = 2'b10;

   typedef struct {
      logic        stall, br;
      logic [31:0] bt;
      logic        jmp;
      logic [31:0] jt;
      logic        run, halt, step;
      logic        en;     // expected o_fetch_en before the edge
      logic [31:0] pc;     // expected outputs after the edge
      logic        pend;
      logic [1:0]  st;
      logic        mis;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic s, logic b, logic [31:0] btv, logic j, logic [31:0] jtv,
                               logic r, logic h, logic p, logic e, logic [31:0] epc,
                               logic epend, logic [1:0] est, logic emis, logic [31:0] ecnt);
      vec_t v;
      v.stall = s; v.br = b; v.bt = btv; v.jmp = j; v.jt = jtv;
      v.run = r; v.halt = h; v.step = p;
      v.en = e; v.pc = epc; v.pend = epend; v.st = est; v.mis = emis; v.cnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      stall = 0; br = 0; bt = 0; jmp = 0; jt = 0; run = 0; halt = 0; step = 0;
   endtask

   // Entered just after a rising edge; leaves just after the next one.
   task automatic run_vec(input int idx, input vec_t v);
      stall = v.stall; br = v.br; bt = v.bt; jmp = v.jmp; jt = v.jt;
      run = v.run; halt = v.halt; step = v.step;
      @(negedge clk);
      chk($sformatf("v%0d fetch_en", idx), {31'b0, fetch_en}, {31'b0, v.en});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", idx), pc, v.pc);
      chk($sformatf("v%0d pc_plus", idx), pc_plus, v.pc + 32'd4);
      chk($sformatf("v%0d pending", idx), {31'b0, pending}, {31'b0, v.pend});
      chk($sformatf("v%0d state", idx), {30'b0, state}, {30'b0, v.st});
      chk($sformatf("v%0d misaligned", idx), {31'b0, misaligned}, {31'b0, v.mis});
      chk($sformatf("v%0d fetch_count", idx), cnt, v.cnt);
      $display("vec %0d: pc=%h pend=%0b st=%0d mis=%0b cnt=%0d", idx, pc, pending, state,
               misaligned, cnt);
   endtask

   initial begin
      //             stall br bt            jmp jt         run halt step  en pc            pend st   mis cnt
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'h4,        0, RUN, 0, 1));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'h8,        0, RUN, 0, 2));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'hC,        0, RUN, 0, 3));
      vecs.push_back(mk(0, 1, 32'h100,      1, 32'h200,    0, 0, 0,      1, 32'h100,      0, RUN, 0, 4));
      vecs.push_back(mk(1, 0, 0,            1, 32'h40,     0, 0, 0,      0, 32'h100,      1, RUN, 0, 4));
      vecs.push_back(mk(1, 0, 0,            0, 0,          0, 0, 0,      0, 32'h100,      1, RUN, 0, 4));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'h40,       0, RUN, 0, 5));
      vecs.push_back(mk(1, 1, 32'h80,       0, 0,          0, 0, 0,      0, 32'h40,       1, RUN, 0, 5));
      vecs.push_back(mk(1, 0, 0,            1, 32'h90,     0, 0, 0,      0, 32'h40,       1, RUN, 0, 5));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'h90,       0, RUN, 0, 6));
      vecs.push_back(mk(1, 1, 32'h300,      0, 0,          0, 0, 0,      0, 32'h90,       1, RUN, 0, 6));
      vecs.push_back(mk(0, 1, 32'h1C,       0, 0,          0, 0, 0,      1, 32'h1C,       0, RUN, 0, 7));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 1, 0,      1, 32'h20,       0, HLT, 0, 8));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      0, 32'h20,       0, HLT, 0, 8));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 1,      0, 32'h20,       0, STP, 0, 8));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'h24,       0, HLT, 0, 9));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      0, 32'h24,       0, HLT, 0, 9));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 1,      0, 32'h24,       0, STP, 0, 9));
      vecs.push_back(mk(1, 0, 0,            0, 0,          0, 0, 0,      0, 32'h24,       0, STP, 0, 9));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 1, 0,      0, 32'h24,       0, HLT, 0, 9));
      vecs.push_back(mk(0, 0, 0,            1, 32'h50,     0, 0, 0,      0, 32'h24,       1, HLT, 0, 9));
      vecs.push_back(mk(0, 0, 0,            0, 0,          1, 0, 0,      0, 32'h24,       1, RUN, 0, 9));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'h50,       0, RUN, 0, 10));
      vecs.push_back(mk(0, 1, 32'h102,      0, 0,          0, 0, 0,      1, 32'h100,      0, RUN, 1, 11));
      vecs.push_back(mk(0, 1, 32'h200,      0, 0,          0, 0, 0,      1, 32'h200,      0, RUN, 1, 12));
      vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 0,          0, 0, 0,      1, 32'hFFFFFFFC, 0, RUN, 1, 13));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'h0,        0, RUN, 1, 14));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'h4,        0, RUN, 1, 15));
      vecs.push_back(mk(0, 0, 0,            0, 0,          1, 1, 1,      1, 32'h8,        0, HLT, 1, 16));
      vecs.push_back(mk(0, 0, 0,            0, 0,          1, 0, 1,      0, 32'h8,        0, STP, 1, 16));
      vecs.push_back(mk(0, 0, 0,            0, 0,          0, 0, 0,      1, 32'hC,        0, HLT, 1, 17));
      vecs.push_back(mk(0, 0, 0,            0, 0,          1, 0, 0,      0, 32'hC,        0, RUN, 1, 17));
      vecs.push_back(mk(1, 0, 0,            1, 32'h77,     0, 0, 0,      0, 32'hC,        1, RUN, 1, 17));

      // Reset state.
      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset pc", pc, 32'h0);
      chk("reset state", {30'b0, state}, {30'b0, RUN});
      chk("reset pending", {31'b0, pending}, 32'h0);
      chk("reset misaligned", {31'b0, misaligned}, 32'h0);
      chk("reset fetch_count", cnt, 32'h0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Asynchronous reset mid-cycle while a redirect is pending.
      drive_idle();
      stall = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("async pc", pc, 32'h0);
      chk("async pending", {31'b0, pending}, 32'h0);
      chk("async misaligned", {31'b0, misaligned}, 32'h0);
      chk("async state", {30'b0, state}, {30'b0, RUN});
      chk("async fetch_count", cnt, 32'h0);
      $display("async reset: pc=%h pend=%0b mis=%0b cnt=%0d", pc, pending, misaligned, cnt);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Misaligned target captured into the pending buffer, then loaded masked.
      run_vec(100, mk(1, 0, 0, 1, 32'h3, 0, 0, 0, 0, 32'h0, 1, RUN, 1, 0));
      run_vec(101, mk(0, 0, 0, 0, 0,     0, 0, 0, 1, 32'h0, 0, RUN, 1, 1));
      run_vec(102, mk(0, 0, 0, 0, 0,     0, 0, 0, 1, 32'h4, 0, RUN, 1, 2));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net: the stimulus is finite, so this only fires on a hung run.
   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_pc_ctrl_unit
